image_line_buffer_ring: RTL
===========================

# image_line_buffer_ring

Parametrised ring of line buffers for the bilinear resize path. It replaces the fixed three-line buffer. The block stores incoming raster lines as horizontal pixel-pair words, each word holding {pix[x], pix[x+1]}, with the right edge replicated. It serves any two consecutive stored lines to the interpolator at a shared column address. New capabilities: configurable pixel width and buffer depth, frame-start flush, occupancy reporting, and a sticky overflow flag.

## Interface
- DATA_W, 24, bits per pixel
- ADDR_W, 11, column address width; max line width 2^ADDR_W
- NUM_BUF, 4, number of line buffers in the ring (≥3)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- frame_start  in  1  one-cycle pulse; flushes all line state
- img_width  in  ADDR_W  active line width in pixels, 2..2^ADDR_W-1, static within a frame
- valid_i  in  1  input pixel strobe
- data_i  in  DATA_W  input pixel
- wr_ready  out  1  a free buffer is available for a new line
- rd_en  in  1  read strobe
- rd_addr  in  ADDR_W  column to read
- rd_release  in  1  one-cycle pulse; oldest stored line is discarded
- rd_ready  out  1  ≥2 complete lines stored
- lines_stored  out  $clog2(NUM_BUF+1)  count of complete lines
- err_overflow  out  1  sticky; pixel dropped
- valid_o  out  1  read data valid
- cur_line_data_o  out  2*DATA_W  {pix[x], pix[x+1]} of the oldest line
- next_line_data_o  out  2*DATA_W  same column of the following line

## Operation
- Storage: NUM_BUF inferred simple dual-port RAMs, each 2^ADDR_W × 2*DATA_W, with registered read.
- State: wr_ptr, rd_ptr (0..NUM_BUF-1, wrap to 0 after NUM_BUF-1), count (complete lines), x_cnt (column), prev_pix, and an edge-pending flag with a latched buffer index.
- Write path: each accepted pixel at column x>0 writes {prev_pix, data_i} to address x-1 of buffer wr_ptr. The write is registered one cycle.
- Last pixel of a line (x == img_width-1):
  - The following cycle writes edge word {data_i, data_i} at address img_width-1 into the latched buffer.
  - count increments in that same cycle.
  - wr_ptr advances and x_cnt clears immediately, so the next line may start on the very next cycle into the next buffer.
- wr_ready = (count + edge_pending) < NUM_BUF.
- A pixel arriving at x==0 while wr_ready==0 is dropped, and err_overflow sets.
- Mid-line pixels are never dropped, because their buffer was free at line start.
- Release: rd_release with count≥1 advances rd_ptr and decrements count. rd_release with count==0 is ignored.
- Simultaneous line completion and release: count is unchanged and both pointers move.
- Reader may re-read the same line pair any number of times before releasing (vertical upscaling).
- rd_ready = count ≥ 2.
- Read path:
  - On rd_en, buffer indices rd_ptr and (rd_ptr+1) mod NUM_BUF are captured along with rd_addr.
  - The outputs mux the two RAM outputs.
  - A rd_en issued when rd_ready==0 returns undefined data but still produces valid_o.
- frame_start: clears count, wr_ptr, rd_ptr, x_cnt, edge_pending and err_overflow. A pending edge write is cancelled. A valid_i in the same cycle is treated as column 0 of the new frame.

## Timing
- Reset values: wr_ready=1, rd_ready=0, lines_stored=0, err_overflow=0, valid_o=0, data outputs 0.
- Write latency:
  - Pixel at cycle t lands in RAM at t+1.
  - Edge word for the last pixel lands at t+2.
  - lines_stored and rd_ready reflect the new line from t+2.
- Read latency: rd_en at cycle t gives valid_o and data at t+2. Fully pipelined, one read per cycle.
- A release at cycle t affects lines_stored/rd_ready from t+1. Reads issued at t still use the pre-release rd_ptr.
- Reset mid-operation clears everything within one cycle. RAM contents are not cleared.

## Test plan
- NUM_BUF=4, img_width=4, line A=1,2,3,4 → RAM words {1,2},{2,3},{3,4},{4,4}. lines_stored=1 at cycle t+2 after the last pixel.
- Two lines A=1..4, B=11..14, then rd_en addr 3 → two cycles later cur={4,4}, next={14,14}, valid_o=1.
- Write 4 lines without release → wr_ready=0 after line 4 completes. Fifth-line pixel → dropped, err_overflow=1. Then rd_release → wr_ready=1.
- Last pixel of line 3 in the same cycle as rd_release with count=2 → lines_stored stays 2, rd_ptr=1, wr_ptr=3.
- Six lines streamed with a release after each pair read → pointers wrap 3→0. Data of lines 5/6 is read correctly from buffers 0/1.
- frame_start asserted mid-line 2 → lines_stored=0, err_overflow=0, rd_ready=0. Next pixel is written at column 0 of buffer 0.

Source files
------------

// File: rtl/image_line_buffer_ring.sv
// Ring of NUM_BUF line buffers holding pixel-pair words {pix[x], pix[x+1]} with the right
// edge replicated; serves the two oldest complete lines at a shared column address.
module image_line_buffer_ring #(
    parameter int DATA_W  = 24,
    parameter int ADDR_W  = 11,
    parameter int NUM_BUF = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_start,
    input  logic [ADDR_W-1:0]            img_width,
    input  logic                         valid_i,
    input  logic [DATA_W-1:0]            data_i,
    output logic                         wr_ready,
    input  logic                         rd_en,
    input  logic [ADDR_W-1:0]            rd_addr,
    input  logic                         rd_release,
    output logic                         rd_ready,
    output logic [$clog2(NUM_BUF+1)-1:0] lines_stored,
    output logic                         err_overflow,
    output logic                         valid_o,
    output logic [2*DATA_W-1:0]          cur_line_data_o,
    output logic [2*DATA_W-1:0]          next_line_data_o
);
    localparam int PTR_W  = $clog2(NUM_BUF);
    localparam int CNT_W  = $clog2(NUM_BUF+1);
    localparam int WORD_W = 2*DATA_W;
    localparam int DEPTH  = 2**ADDR_W;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_BUF-1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] x_cnt_q, x_cnt_d;
    logic [DATA_W-1:0] prev_pix_q, prev_pix_d;
    logic              edge_pend_q, edge_pend_d;
    logic [PTR_W-1:0]  edge_buf_q, edge_buf_d;
    logic              err_q, err_d;

    logic              rd_v1_q, rd_v1_d;
    logic [PTR_W-1:0]  cur_sel_q, cur_sel_d, nxt_sel_q, nxt_sel_d;
    logic              valid_q, valid_d;
    logic [WORD_W-1:0] cur_data_q, cur_data_d, nxt_data_q, nxt_data_d;

    logic              wr_en;
    logic [PTR_W-1:0]  wr_buf;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              line_done, release_ok, can_start;
    logic [ADDR_W-1:0] col, last_col;
    logic [PTR_W-1:0]  buf_sel;

    logic [NUM_BUF-1:0][WORD_W-1:0] ram_rd;

    assign last_col = img_width - ADDR_W'(1);
    // A line whose edge word is still pending already owns its buffer.
    assign wr_ready = ({1'b0, count_q} + {{CNT_W{1'b0}}, edge_pend_q}) < (CNT_W+1)'(NUM_BUF);
    assign rd_ready = count_q >= CNT_W'(2);
    assign lines_stored = count_q;
    assign err_overflow = err_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        x_cnt_d     = x_cnt_q;
        prev_pix_d  = prev_pix_q;
        edge_pend_d = edge_pend_q;
        edge_buf_d  = edge_buf_q;
        err_d       = err_q;
        wr_en       = 1'b0;
        wr_buf      = edge_buf_q;
        wr_addr     = last_col;
        wr_data     = {prev_pix_q, prev_pix_q};
        line_done   = 1'b0;

        // The edge cycle always sees column 0 on the pixel side, so the write port is free.
        if (edge_pend_q && !frame_start) begin
            wr_en       = 1'b1;
            line_done   = 1'b1;
            edge_pend_d = 1'b0;
        end

        release_ok = rd_release && (count_q != '0) && !frame_start;
        if (frame_start) begin
            count_d     = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            x_cnt_d     = '0;
            edge_pend_d = 1'b0;
            err_d       = 1'b0;
        end else begin
            if (line_done && !release_ok)
                count_d = count_q + CNT_W'(1);
            else if (!line_done && release_ok)
                count_d = count_q - CNT_W'(1);
            if (release_ok)
                rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        col       = frame_start ? '0 : x_cnt_q;
        buf_sel   = frame_start ? '0 : wr_ptr_q;
        can_start = frame_start || wr_ready;
        if (valid_i) begin
            if (col == '0 && !can_start) begin
                err_d = 1'b1;
            end else begin
                prev_pix_d = data_i;
                if (col != '0) begin
                    wr_en   = 1'b1;
                    wr_buf  = buf_sel;
                    wr_addr = col - ADDR_W'(1);
                    wr_data = {prev_pix_q, data_i};
                end
                if (col == last_col) begin
                    x_cnt_d     = '0;
                    wr_ptr_d    = ptr_inc(buf_sel);
                    edge_pend_d = 1'b1;
                    edge_buf_d  = buf_sel;
                end else begin
                    x_cnt_d = col + ADDR_W'(1);
                end
            end
        end
    end

    always_comb begin
        rd_v1_d    = rd_en;
        cur_sel_d  = rd_en ? rd_ptr_q : cur_sel_q;
        nxt_sel_d  = rd_en ? ptr_inc(rd_ptr_q) : nxt_sel_q;
        valid_d    = rd_v1_q;
        cur_data_d = rd_v1_q ? ram_rd[cur_sel_q] : cur_data_q;
        nxt_data_d = rd_v1_q ? ram_rd[nxt_sel_q] : nxt_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            x_cnt_q     <= '0;
            prev_pix_q  <= '0;
            edge_pend_q <= 1'b0;
            edge_buf_q  <= '0;
            err_q       <= 1'b0;
            rd_v1_q     <= 1'b0;
            cur_sel_q   <= '0;
            nxt_sel_q   <= '0;
            valid_q     <= 1'b0;
            cur_data_q  <= '0;
            nxt_data_q  <= '0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            x_cnt_q     <= x_cnt_d;
            prev_pix_q  <= prev_pix_d;
            edge_pend_q <= edge_pend_d;
            edge_buf_q  <= edge_buf_d;
            err_q       <= err_d;
            rd_v1_q     <= rd_v1_d;
            cur_sel_q   <= cur_sel_d;
            nxt_sel_q   <= nxt_sel_d;
            valid_q     <= valid_d;
            cur_data_q  <= cur_data_d;
            nxt_data_q  <= nxt_data_d;
        end
    end

    for (genvar b = 0; b < NUM_BUF; b++) begin : g_buf
        logic [WORD_W-1:0] mem [DEPTH];
        logic [WORD_W-1:0] rd_word;

        // NOTE: RAM storage and its read register are deliberately left out of reset so
        // they map onto block RAM; stale contents are never exposed as a complete line.
        always_ff @(posedge clk) begin
            if (wr_en && wr_buf == PTR_W'(b))
                mem[wr_addr] <= wr_data;
            if (rd_en)
                rd_word <= mem[rd_addr];
        end

        assign ram_rd[b] = rd_word;
    end

    assign valid_o          = valid_q;
    assign cur_line_data_o  = cur_data_q;
    assign next_line_data_o = nxt_data_q;
endmodule
